uart_rx_sink: RTL and testbench
===============================

# uart_rx_sink

Synthesizable UART receiver that sits directly downstream of the SoC's `UART_TXD` pin. It deserializes 8N1 frames into bytes and buffers them in a 4-entry FIFO behind a valid/ready handshake. It flags framing errors and overflow. In simulation it lets the top-level bench capture firmware console output cycle-accurately; on the board it serves as the loopback checker.

## Interface
- `CLKS_PER_BIT`, default 868, iCLK cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `HALF`, default `CLKS_PER_BIT>>1`, cycles from start-bit detection to the start-bit sample; derived, not overridden.
- `iCLK` in 1, single clock; all logic on its rising edge.
- `iRST` in 1, reset; synchronous, active-high.
- `UART_RXD` in 1, serial line, idle high; connects to the SoC `UART_TXD`.
- `oDATA` out 8, head-of-FIFO byte; valid only while `oVALID`=1.
- `oVALID` out 1, FIFO non-empty.
- `iREADY` in 1, consumer accepts `oDATA` when `oVALID & iREADY`.
- `oFERR` out 1, sticky framing error (stop bit sampled low).
- `oOVF` out 1, sticky overflow (byte completed while FIFO full and no pop).
- `oBUSY` out 1, receiver FSM not in IDLE.

## Operation
- `UART_RXD` passes through a 2-flop synchronizer (both flops reset to 1); FSM uses sync output `rxs`.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: `rxs`=0 → START, `cnt`←HALF-1.
- All timed states: `cnt` decrements each cycle; action taken on the edge where `cnt`==0.
- START sample: `rxs`=0 → DATA, `cnt`←CLKS_PER_BIT-1, `bit`←0. `rxs`=1 → glitch, back to IDLE, nothing recorded.
- DATA sample: shift `rxs` into `sh` LSB-first (`sh`←{rxs,sh[7:1]}), `cnt`←CLKS_PER_BIT-1. After bit 7 → STOP.
- STOP sample: `rxs`=1 → push `sh` into FIFO, → IDLE. `rxs`=0 → set `oFERR`, discard byte, → BREAK.
- BREAK: stay until `rxs`=1, then → IDLE. No start detection while in BREAK.
- FIFO: 4 entries, 2-bit read/write pointers plus 3-bit count; pointers wrap 3→0.
- Pop when `oVALID & iREADY`.
- Push with count=4 and no simultaneous pop: byte dropped, `oOVF` set, FIFO unchanged.
- Push and pop in the same cycle at count=4: both happen, count stays 4, no overflow.
- Push and pop in the same cycle at count=0: no pop (oVALID=0); byte enqueued.
- `oFERR`/`oOVF` clear only on reset.
- `iRST` mid-frame: FSM→IDLE, `cnt`/`bit`/`sh` zeroed, FIFO flushed, flags cleared.

## Timing
- Reset values: `oDATA`=0, `oVALID`=0, `oFERR`=0, `oOVF`=0, `oBUSY`=0. Synchronizer flops=1.
- Edge 0 is the first iCLK edge sampling `UART_RXD`=0. `rxs`=0 after edge 1; FSM enters START at edge 2.
- Start-bit sample: edge 2+HALF.
- Data bit k sample: edge 2+HALF+(k+1)·CLKS_PER_BIT.
- Stop-bit sample: edge N = 2+HALF+9·CLKS_PER_BIT.
- `oVALID`=1 and `oDATA` valid from edge N (registered). First cycle consumer can pop is the one ending at edge N+1.
- `oFERR`/`oOVF` assert at edge N of the offending frame.
- `oBUSY`=1 from edge 2 through edge N (or until BREAK exits); 0 in IDLE.
- Back-to-back frames: a start edge arriving any time after the stop sample is detected; no dead time beyond the synchronizer.
- `oDATA` is combinational from FIFO head memory via read pointer; holds stable while `oVALID`=1 and not popped.

## Test plan
- CLKS_PER_BIT=16 (HALF=8), `iREADY`=1, send 0x55 starting at edge 0 → `oVALID` rises at edge 154, `oDATA`=0x55 for exactly one cycle, `oFERR`=`oOVF`=0.
- `iREADY`=0, send 0x41,0x42,0x43,0x44 back-to-back → `oVALID`=1 from first frame on, then assert `iREADY` → pops 0x41,0x42,0x43,0x44 in order, `oVALID`=0 after.
- `iREADY`=0, send five bytes 0x01..0x05 → `oOVF`=1 at fifth stop sample; drain yields 0x01..0x04 only.
- Send 0xA5 with stop bit forced low and line held low 40 cycles → `oFERR`=1, no FIFO push, `oBUSY`=1 until line returns high; next frame 0x3C received correctly.
- 3-cycle low glitch on idle line → FSM returns to IDLE at start sample, no push, no flags.
- Assert `iRST` for one cycle during bit 4 of a frame with two bytes queued → all outputs at reset values next cycle; following clean frame 0x7E received normally.

Source files
------------

// File: rtl/uart_rx_sink_if.sv
// Byte stream out of the UART receiver FIFO: valid/ready handshake.
interface uart_rx_sink_if;
    logic [7:0] oDATA;
    logic       oVALID;
    logic       iREADY;

    modport master (output oDATA, output oVALID, input iREADY);
    modport slave  (input oDATA, input oVALID, output iREADY);
endinterface

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver feeding a 4-entry byte FIFO, with sticky framing-error
// and overflow flags. Bit timing counts from the synchronized start edge.
module uart_rx_sink #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic           iCLK,
    input  logic           iRST,
    input  logic           UART_RXD,
    uart_rx_sink_if.master out_if,
    output logic           oFERR,
    output logic           oOVF,
    output logic           oBUSY
);
    localparam int unsigned HALF = CLKS_PER_BIT >> 1;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic          sync1_q;
    logic          rxs_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          ferr_q;

    logic [7:0]    mem_q [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    logic          ovf_q;

    logic          push;
    logic          pop;
    logic          wr_en;
    logic          ovf_set;

    // Two-flop synchronizer on the asynchronous serial line (idles high).
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= UART_RXD;
            rxs_q   <= sync1_q;
        end
    end

    // Receiver FSM: every timed state acts on the cycle its counter hits zero.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ferr_q  <= 1'b0;
        end else begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= ST_START;
                        cnt_q   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (cnt_q == '0) begin
                        if (!rxs_q) begin
                            state_q <= ST_DATA;
                            cnt_q   <= CNT_BIT;
                            bit_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (cnt_q == '0) begin
                        sh_q  <= {rxs_q, sh_q[7:1]};
                        cnt_q <= CNT_BIT;
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt_q == '0) begin
                        if (rxs_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A good stop bit hands the assembled byte to the FIFO on the same edge.
    assign push = (state_q == ST_STOP) && (cnt_q == '0) && rxs_q;

    // FIFO next-state: a pop frees the slot a full-FIFO push needs.
    always_comb begin
        pop      = (count_q != 3'd0) && out_if.iREADY;
        wr_en    = push && ((count_q != 3'd4) || pop);
        ovf_set  = push && (count_q == 3'd4) && !pop;
        count_d  = count_q + {2'b00, wr_en} - {2'b00, pop};
        wr_ptr_d = wr_ptr_q + {1'b0, wr_en};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
    end

    // FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= sh_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_q | ovf_set;
        end
    end

    assign out_if.oDATA  = mem_q[rd_ptr_q];
    assign out_if.oVALID = (count_q != 3'd0);
    assign oFERR         = ferr_q;
    assign oOVF          = ovf_q;
    assign oBUSY         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_sink.sv
// Bench for uart_rx_sink: directed scenarios plus random frames, checked
// against a frame-level model (byte queue updated at each stop-sample edge).
module tb_uart_rx_sink;
    localparam int unsigned CPB    = 16;
    localparam int unsigned HALF   = CPB >> 1;
    localparam int unsigned NO_RST = 32'hFFFF_FFFF;

    logic iCLK     = 1'b0;
    logic iRST     = 1'b1;
    logic UART_RXD = 1'b1;
    logic oFERR, oOVF, oBUSY;

    uart_rx_sink_if u_if ();

    uart_rx_sink #(.CLKS_PER_BIT(CPB)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .UART_RXD (UART_RXD),
        .out_if   (u_if),
        .oFERR    (oFERR),
        .oOVF     (oOVF),
        .oBUSY    (oBUSY)
    );

    initial forever #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [31:0] edge_n;
        logic [7:0]  d;
        logic        good;
    } frm_t;

    frm_t        pend[$];
    logic [7:0]  exp_q[$];
    logic        ferr_m = 1'b0;
    logic        ovf_m  = 1'b0;
    int unsigned cyc    = 0;
    logic [7:0]  got_q[$];
    int unsigned vq[$];
    bit          chk_en   = 1'b0;
    bit          rand_rdy = 1'b0;
    int unsigned rdy_pct  = 50;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one update per clock edge, frame outcomes scheduled by the sender.
    initial begin : model
        bit          popped;
        int unsigned pre;
        frm_t        f;
        forever begin
            @(posedge iCLK);
            cyc = cyc + 1;
            if (iRST) begin
                exp_q.delete();
                pend.delete();
                ferr_m = 1'b0;
                ovf_m  = 1'b0;
            end else begin
                pre    = exp_q.size();
                popped = (pre != 0) && u_if.iREADY;
                if (popped) void'(exp_q.pop_front());
                if (pend.size() != 0 && pend[0].edge_n == cyc) begin
                    f = pend.pop_front();
                    if (!f.good) ferr_m = 1'b1;
                    else if (pre < 4 || popped) exp_q.push_back(f.d);
                    else ovf_m = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus logs of valid cycles and pops.
    initial begin : monitor
        forever begin
            @(negedge iCLK);
            if (chk_en) begin
                chk("valid", 32'(u_if.oVALID), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) chk("data", 32'(u_if.oDATA), 32'(exp_q[0]));
                chk("ferr", 32'(oFERR), 32'(ferr_m));
                chk("ovf", 32'(oOVF), 32'(ovf_m));
                if (u_if.oVALID) vq.push_back(cyc);
                if (u_if.oVALID && u_if.iREADY) got_q.push_back(u_if.oDATA);
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
        if (rand_rdy) u_if.iREADY = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic idle(input int unsigned n);
        UART_RXD = 1'b1;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
    endtask

    // Drives one frame; stop=0 with hold extends the low line; rst_at pulses reset mid-frame.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int unsigned hold, input int unsigned rst_at);
        int unsigned c     = cyc;
        int unsigned total = 10 * CPB + hold;
        logic [9:0]  fr;
        frm_t        f;
        fr = {stop, d, 1'b0};
        if (rst_at == NO_RST) begin
            f.edge_n = c + 3 + HALF + 9 * CPB;
            f.d      = d;
            f.good   = stop;
            pend.push_back(f);
        end
        for (int unsigned i = 0; i < total; i++) begin
            if (i > rst_at) UART_RXD = 1'b1;
            else if (i < 10 * CPB) UART_RXD = fr[i / CPB];
            else UART_RXD = 1'b0;
            if (i == rst_at) begin
                chk("busy_pre_rst", 32'(oBUSY), 32'd1);
                iRST = 1'b1;
            end
            tick();
            if (i == rst_at) begin
                chk("rst_valid", 32'(u_if.oVALID), 32'd0);
                chk("rst_data", 32'(u_if.oDATA), 32'd0);
                chk("rst_ferr", 32'(oFERR), 32'd0);
                chk("rst_ovf", 32'(oOVF), 32'd0);
                chk("rst_busy", 32'(oBUSY), 32'd0);
                iRST = 1'b0;
            end
        end
        UART_RXD = 1'b1;
    endtask

    task automatic chk_pops(input string tag, input int unsigned base,
                            input logic [39:0] bytes, input int unsigned n);
        chk({tag, "_n"}, 32'(got_q.size() - base), 32'(n));
        for (int unsigned k = 0; k < n; k++) begin
            chk(tag, 32'(got_q[base + k]), 32'(bytes[8 * k +: 8]));
        end
    endtask

    initial begin : main
        int unsigned c0, vb, gb, gap;
        logic [7:0]  d;
        logic        stop;

        u_if.iREADY = 1'b0;
        repeat (3) tick();
        iRST = 1'b0;
        chk("reset_data", 32'(u_if.oDATA), 32'd0);
        chk("reset_valid", 32'(u_if.oVALID), 32'd0);
        chk("reset_ferr", 32'(oFERR), 32'd0);
        chk("reset_ovf", 32'(oOVF), 32'd0);
        chk("reset_busy", 32'(oBUSY), 32'd0);
        chk_en = 1'b1;

        // Single byte, consumer always ready: valid for exactly one cycle at edge 154.
        u_if.iREADY = 1'b1;
        c0 = cyc;
        vb = vq.size();
        gb = got_q.size();
        send_frame(8'h55, 1'b1, 0, NO_RST);
        idle(5);
        chk("t1_vcycles", 32'(vq.size() - vb), 32'd1);
        chk("t1_rise", 32'(vq[vb] - c0), 32'(1 + 2 + HALF + 9 * CPB));
        chk_pops("t1_pop", gb, 40'h55, 1);
        chk("t1_ferr", 32'(oFERR), 32'd0);
        chk("t1_ovf", 32'(oOVF), 32'd0);

        // Four back-to-back bytes buffered, then drained in order.
        do_reset();
        u_if.iREADY = 1'b0;
        for (int unsigned k = 0; k < 4; k++) send_frame(8'h41 + 8'(k), 1'b1, 0, NO_RST);
        chk("t2_full_valid", 32'(u_if.oVALID), 32'd1);
        gb = got_q.size();
        u_if.iREADY = 1'b1;
        idle(6);
        chk_pops("t2_pop", gb, 40'h44434241, 4);
        chk("t2_empty", 32'(u_if.oVALID), 32'd0);

        // Fifth byte into a full FIFO is dropped and flags overflow.
        do_reset();
        u_if.iREADY = 1'b0;
        for (int unsigned k = 0; k < 5; k++) send_frame(8'h01 + 8'(k), 1'b1, 0, NO_RST);
        chk("t3_ovf", 32'(oOVF), 32'd1);
        gb = got_q.size();
        u_if.iREADY = 1'b1;
        idle(6);
        chk_pops("t3_pop", gb, 40'h04030201, 4);

        // Framing error followed by a held-low line, then a clean frame.
        do_reset();
        u_if.iREADY = 1'b1;
        send_frame(8'hA5, 1'b0, 40, NO_RST);
        chk("t4_busy_break", 32'(oBUSY), 32'd1);
        chk("t4_ferr", 32'(oFERR), 32'd1);
        chk("t4_nopush", 32'(u_if.oVALID), 32'd0);
        idle(5);
        chk("t4_busy_exit", 32'(oBUSY), 32'd0);
        gb = got_q.size();
        send_frame(8'h3C, 1'b1, 0, NO_RST);
        idle(3);
        chk_pops("t4_pop", gb, 40'h3C, 1);
        chk("t4_ferr_sticky", 32'(oFERR), 32'd1);

        // Short low glitch: start sample sees high, nothing recorded.
        do_reset();
        UART_RXD = 1'b0;
        repeat (3) tick();
        UART_RXD = 1'b1;
        repeat (3) tick();
        chk("t5_busy_start", 32'(oBUSY), 32'd1);
        repeat (14) tick();
        chk("t5_busy_idle", 32'(oBUSY), 32'd0);
        chk("t5_valid", 32'(u_if.oVALID), 32'd0);
        chk("t5_ferr", 32'(oFERR), 32'd0);
        chk("t5_ovf", 32'(oOVF), 32'd0);

        // Reset during data bit 4 with two bytes queued, then a clean frame.
        do_reset();
        u_if.iREADY = 1'b0;
        send_frame(8'h11, 1'b1, 0, NO_RST);
        send_frame(8'h22, 1'b1, 0, NO_RST);
        chk("t6_queued", 32'(u_if.oVALID), 32'd1);
        send_frame(8'h99, 1'b1, 0, 5 * CPB + HALF);
        idle(4);
        u_if.iREADY = 1'b1;
        gb = got_q.size();
        send_frame(8'h7E, 1'b1, 0, NO_RST);
        idle(3);
        chk_pops("t6_pop", gb, 40'h7E, 1);
        chk("t6_ferr", 32'(oFERR), 32'd0);
        chk("t6_ovf", 32'(oOVF), 32'd0);

        // Random bytes, gaps, occasional bad stop bits and a random consumer.
        do_reset();
        rand_rdy = 1'b1;
        for (int unsigned k = 0; k < 40; k++) begin
            rdy_pct = (k < 20) ? 20 : 80;
            d       = 8'($urandom);
            stop    = ($urandom_range(0, 9) != 0);
            if (stop) begin
                send_frame(d, 1'b1, 0, NO_RST);
                gap = $urandom_range(0, 4);
            end else begin
                send_frame(d, 1'b0, $urandom_range(0, 20), NO_RST);
                gap = $urandom_range(2, 6);
            end
            idle(gap);
        end
        rand_rdy    = 1'b0;
        u_if.iREADY = 1'b1;
        idle(10);
        chk("rand_drained", 32'(u_if.oVALID), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
